// File: rtl/core_pkg.sv
// Shared core types and widths.
// Entry layout used by the fetch-side instruction buffer.
package core_pkg;

  localparam int XLEN = 64;
  localparam int IW   = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [IW-1:0]   instr;
  } ibuf_entry_t;

endpackage

// File: rtl/sync_fifo_ctrl.sv
// Pointer and occupancy control for a power-of-two FIFO.
// Flush wins over push and pop; full blocks push even with a pop.
module sync_fifo_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push_req,
  input  logic                       pop_req,
  output logic                       wr_en,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rd_en;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign wr_en  = push_req && !full && !flush;
  assign rd_en  = pop_req && !empty && !flush;
  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;

  // Next pointers and occupancy; flush clears everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
    unique case (1'b1)
      flush: begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end
      (wr_en && !rd_en): count_d = count_q + CW'(1);
      (rd_en && !wr_en): count_d = count_q - CW'(1);
      default: ;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ifu_ibuf.sv
// Instruction buffer between fetch and decode.
// Registered-only outputs; no fall-through from in_* to out_*.
module ifu_ibuf #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4,
  parameter int IW    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [IW-1:0]           in_instr,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [XLEN-1:0]         out_pc,
  output logic [IW-1:0]           out_instr,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  count
);

  import core_pkg::*;

  localparam int PW = $clog2(DEPTH);

  logic          wr_en;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          empty;

  ibuf_entry_t   mem_q [DEPTH];
  ibuf_entry_t   mem_d [DEPTH];
  ibuf_entry_t   head;

  sync_fifo_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push_req (in_valid),
    .pop_req  (out_ready),
    .wr_en    (wr_en),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  // Write the incoming pair into the tail slot on accept.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_ptr] = '{pc: in_pc, instr: in_instr};
    end
  end

  // Storage; cleared only by reset, flush just drops pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign head      = mem_q[rd_ptr];
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign out_valid = !empty;
  assign in_ready  = !full;

endmodule

// File: tb/tb_ifu_ibuf.sv
// Scoreboard bench for ifu_ibuf.
// Queue reference model checked every cycle on the falling edge.
module tb_ifu_ibuf;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready = 1'b0;
  logic [2:0]  count;

  int n_tot = 0;
  int n_pass = 0;

  logic [95:0] exp_q [$];

  always #5 clk = ~clk;

  ifu_ibuf #(
    .XLEN  (64),
    .DEPTH (DEPTH),
    .IW    (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ready (out_ready),
    .count     (count)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic v, input logic [63:0] pc,
                       input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_pc     = pc;
    in_instr  = $urandom;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Monitor: compare DUT against model, then advance model.
  always @(negedge clk) begin
    int sz;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      sz = exp_q.size();
      chk("count", 64'(count), 64'(sz));
      chk("count_le_depth", 64'(count <= 3'(DEPTH)), 64'd1);
      chk("out_valid", 64'(out_valid), 64'(sz != 0));
      chk("in_ready", 64'(in_ready), 64'(sz < DEPTH));
      if (sz != 0) begin
        chk("head_pc", out_pc, exp_q[0][95:32]);
        chk("head_instr", 64'(out_instr), 64'(exp_q[0][31:0]));
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_ready && sz != 0) void'(exp_q.pop_front());
        if (in_valid && sz < DEPTH) exp_q.push_back({in_pc, in_instr});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] base;
    logic [63:0] pc;
    base = 64'h8000_0000;

    in_valid = 1'b1;
    in_pc    = 64'h1234;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_pc", out_pc, 64'd0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rel_count", 64'(count), 64'd0);
    chk("rel_out_valid", 64'(out_valid), 64'd0);

    for (int i = 0; i < 4; i++) drive(1'b1, base + 64'(4 * i), 1'b0, 1'b0);
    drive(1'b1, base + 64'h10, 1'b0, 1'b0);
    @(negedge clk);
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, base + 64'h10, 1'b0, 1'b0);
    @(negedge clk);
    chk("fifth_refused", 64'(count), 64'd4);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 64'd0, 1'b1, 1'b0);
      @(negedge clk);
      chk("drain_pc", out_pc, base + 64'(4 * k));
    end
    drive(1'b0, 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("drain_empty", 64'(out_valid), 64'd0);

    for (int i = 0; i < 20; i++) begin
      drive(1'b1, base + 64'(4 * i), 1'b1, 1'b0);
      @(negedge clk);
      if (i > 0) begin
        chk("stream_pc", out_pc, base + 64'(4 * (i - 1)));
        chk("stream_count", 64'(count), 64'd1);
      end
    end
    drive(1'b0, 64'd0, 1'b1, 1'b0);
    drive(1'b0, 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("stream_done", 64'(out_valid), 64'd0);

    for (int i = 0; i < 4; i++) drive(1'b1, base + 64'(4 * i), 1'b0, 1'b0);
    drive(1'b1, base + 64'h30, 1'b1, 1'b0);
    drive(1'b0, 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_pp_count", 64'(count), 64'd3);
    chk("full_pp_ready", 64'(in_ready), 64'd1);
    chk("full_pp_head", out_pc, base + 64'h4);

    drive(1'b1, base + 64'h40, 1'b1, 1'b1);
    drive(1'b1, 64'h8000_1000, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    drive(1'b0, 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_flush_count", 64'(count), 64'd1);
    chk("post_flush_pc", out_pc, 64'h8000_1000);
    drive(1'b0, 64'd0, 1'b1, 1'b0);
    drive(1'b0, 64'd0, 1'b0, 1'b0);

    drive(1'b1, base, 1'b0, 1'b0);
    drive(1'b1, base + 64'h4, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    pc = 64'h8000_2000;
    for (int c = 0; c < 1000; c++) begin
      drive($urandom_range(0, 3) != 0, pc, $urandom_range(0, 2) != 0,
            $urandom_range(0, 31) == 0);
      pc = pc + 64'd4;
    end
    drive(1'b0, 64'd0, 1'b1, 1'b0);
    repeat (6) drive(1'b0, 64'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("final_empty", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
